// File: rtl/reg_rename_file_if.sv
// Issue/read/commit/flush bundle between issue logic, the ROB and the rename file.
interface reg_rename_file_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int Q_WIDTH        = 4
);
    logic                      has_issue;
    logic [REG_ADDR_WIDTH-1:0] issue_rd;
    logic                      issue_rd_en;
    logic [Q_WIDTH-1:0]        issue_tag;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic                      rs1_busy;
    logic [Q_WIDTH-1:0]        rs1_tag;
    logic [31:0]               rs1_val;
    logic                      rs2_busy;
    logic [Q_WIDTH-1:0]        rs2_tag;
    logic [31:0]               rs2_val;
    logic                      commit_modify_regfile;
    logic [REG_ADDR_WIDTH-1:0] commit_reg_addr;
    logic [Q_WIDTH-1:0]        Commit_Q;
    logic [31:0]               Commit_V;
    logic                      control_hazard;

    modport master (
        output has_issue, issue_rd, issue_rd_en, issue_tag, rs1_addr, rs2_addr,
               commit_modify_regfile, commit_reg_addr, Commit_Q, Commit_V, control_hazard,
        input  rs1_busy, rs1_tag, rs1_val, rs2_busy, rs2_tag, rs2_val
    );

    modport slave (
        input  has_issue, issue_rd, issue_rd_en, issue_tag, rs1_addr, rs2_addr,
               commit_modify_regfile, commit_reg_addr, Commit_Q, Commit_V, control_hazard,
        output rs1_busy, rs1_tag, rs1_val, rs2_busy, rs2_tag, rs2_val
    );
endinterface

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register ROB rename tags.
// Two combinational read ports with commit bypass; register 0 is hardwired zero.
module rrf_read_port #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int Q_WIDTH        = 4,
    parameter int NREG           = 2**REG_ADDR_WIDTH
) (
    input  logic [REG_ADDR_WIDTH-1:0]     rs,
    input  logic [NREG-1:0]               busy_q,
    input  logic [NREG-1:0][Q_WIDTH-1:0]  tag_q,
    input  logic [NREG-1:0][31:0]         val_q,
    input  logic                          commit_en,
    input  logic [REG_ADDR_WIDTH-1:0]     commit_addr,
    input  logic [Q_WIDTH-1:0]            commit_q,
    input  logic [31:0]                   commit_v,
    output logic                          busy,
    output logic [Q_WIDTH-1:0]            tag,
    output logic [31:0]                   val
);
    always_comb begin
        busy = busy_q[rs];
        tag  = tag_q[rs];
        val  = val_q[rs];
        if (rs == '0) begin
            busy = 1'b0;
            val  = '0;
        end else if (commit_en && commit_addr == rs && busy_q[rs] && tag_q[rs] == commit_q) begin
            // producer retires this cycle: hand its value straight to the reader
            busy = 1'b0;
            val  = commit_v;
        end
    end
endmodule

module reg_rename_file #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int Q_WIDTH        = 4
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    reg_rename_file_if.slave rf
);
    localparam int NREG = 2**REG_ADDR_WIDTH;
    localparam int NRP  = 2;

    logic [NREG-1:0]              busy_q;
    logic [NREG-1:0][Q_WIDTH-1:0] tag_q;
    logic [NREG-1:0][31:0]        val_q;

    logic commit_wr, rename;
    assign commit_wr = rf.commit_modify_regfile && rf.commit_reg_addr != '0;
    assign rename    = rf.has_issue && rf.issue_rd_en && rf.issue_rd != '0 && !rf.control_hazard;

    // Later assignments win: rename overrides a same-cycle commit clear, flush overrides both.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q <= '0;
            tag_q  <= '0;
            val_q  <= '0;
        end else if (rdy_in) begin
            if (commit_wr) begin
                val_q[rf.commit_reg_addr] <= rf.Commit_V;
                if (tag_q[rf.commit_reg_addr] == rf.Commit_Q)
                    busy_q[rf.commit_reg_addr] <= 1'b0;
            end
            if (rf.control_hazard) begin
                busy_q <= '0;
            end else if (rename) begin
                busy_q[rf.issue_rd] <= 1'b1;
                tag_q[rf.issue_rd]  <= rf.issue_tag;
            end
        end
    end

    logic [NRP-1:0][REG_ADDR_WIDTH-1:0] rp_addr;
    logic [NRP-1:0]                     rp_busy;
    logic [NRP-1:0][Q_WIDTH-1:0]        rp_tag;
    logic [NRP-1:0][31:0]               rp_val;

    assign rp_addr[0] = rf.rs1_addr;
    assign rp_addr[1] = rf.rs2_addr;

    for (genvar p = 0; p < NRP; p++) begin : g_rp
        rrf_read_port #(
            .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
            .Q_WIDTH       (Q_WIDTH),
            .NREG          (NREG)
        ) u_rp (
            .rs         (rp_addr[p]),
            .busy_q     (busy_q),
            .tag_q      (tag_q),
            .val_q      (val_q),
            .commit_en  (rf.commit_modify_regfile),
            .commit_addr(rf.commit_reg_addr),
            .commit_q   (rf.Commit_Q),
            .commit_v   (rf.Commit_V),
            .busy       (rp_busy[p]),
            .tag        (rp_tag[p]),
            .val        (rp_val[p])
        );
    end

    assign rf.rs1_busy = rp_busy[0];
    assign rf.rs1_tag  = rp_tag[0];
    assign rf.rs1_val  = rp_val[0];
    assign rf.rs2_busy = rp_busy[1];
    assign rf.rs2_tag  = rp_tag[1];
    assign rf.rs2_val  = rp_val[1];
endmodule
